// File: rtl/sm3_blk_asm_if.sv
// sm3_blk_asm_if: padder-side beat stream and compression-side block handshake
interface sm3_blk_asm_if #(parameter int INPT_DW = 32);
  logic [INPT_DW-1:0] pad_d_i;
  logic               pad_vld_i;
  logic               pad_lst_i;
  logic               pad_ena_o;
  logic [511:0]       blk_d_o;
  logic               blk_vld_o;
  logic               blk_rdy_i;
  logic               blk_fst_o;
  logic               blk_lst_o;
  logic               ovf_err_o;
  logic               frm_err_o;
  logic               err_clr_i;
  modport master (
    output pad_d_i, pad_vld_i, pad_lst_i, blk_rdy_i, err_clr_i,
    input  pad_ena_o, blk_d_o, blk_vld_o, blk_fst_o, blk_lst_o, ovf_err_o, frm_err_o
  );
  modport slave (
    input  pad_d_i, pad_vld_i, pad_lst_i, blk_rdy_i, err_clr_i,
    output pad_ena_o, blk_d_o, blk_vld_o, blk_fst_o, blk_lst_o, ovf_err_o, frm_err_o
  );
endinterface

// File: rtl/sm3_blk_asm.sv
// sm3_blk_asm: assembles padded SM3 beats into 512-bit blocks through a fill/hold double buffer
module sm3_blk_asm #(parameter int INPT_DW = 32) (
  input logic         clk,
  input logic         rst_n,
  sm3_blk_asm_if.slave bus
);
  localparam int WPB = INPT_DW / 32;
  if (INPT_DW != 32 && INPT_DW != 64) begin : g_bad_dw
    $error("sm3_blk_asm: INPT_DW must be 32 or 64");
  end
  logic [31:0]  fill_w [16];
  logic [4:0]   fill_cnt;
  logic         fill_fst, fill_lst, fst_pend;
  logic [511:0] hold_d;
  logic         hold_vld, hold_fst, hold_lst;
  logic         ovf_err, frm_err;
  logic         xfer, wr, drop, cmpl, frm_fire;
  logic [4:0]   wr_idx;
  logic [511:0] fill_pk;
  // transfer/write qualification; a transfer frees the fill register for a same-cycle beat at W0
  always_comb begin
    xfer = fill_cnt == 5'd16 && (!hold_vld || bus.blk_rdy_i);
    wr_idx = xfer ? 5'd0 : fill_cnt;
    wr = bus.pad_vld_i && (fill_cnt != 5'd16 || xfer);
    drop = bus.pad_vld_i && !wr;
    cmpl = wr_idx + 5'(WPB) == 5'd16;
    frm_fire = wr && bus.pad_lst_i && !cmpl;
    fill_pk = '0;
    for (int i = 0; i < 16; i++) fill_pk[511-32*i -: 32] = fill_w[i];
  end
  // fill register: word capture, block flags, partial-block discard on a misframed last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
      fill_fst <= 1'b0;
      fill_lst <= 1'b0;
      fst_pend <= 1'b1;
      for (int i = 0; i < 16; i++) fill_w[i] <= '0;
    end else if (wr) begin
      for (int j = 0; j < WPB; j++) fill_w[4'(wr_idx + 5'(j))] <= bus.pad_d_i[INPT_DW-1-32*j -: 32];
      fill_cnt <= frm_fire ? 5'd0 : wr_idx + 5'(WPB);
      fill_lst <= bus.pad_lst_i && cmpl;
      if (wr_idx == 5'd0) fill_fst <= fst_pend;
      fst_pend <= bus.pad_lst_i || (fst_pend && wr_idx != 5'd0);
    end else if (xfer) begin
      fill_cnt <= '0;
    end
  end
  // hold register presented to the compression core; stable until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_d <= '0;
      hold_vld <= 1'b0;
      hold_fst <= 1'b0;
      hold_lst <= 1'b0;
    end else if (xfer) begin
      hold_d <= fill_pk;
      hold_vld <= 1'b1;
      hold_fst <= fill_fst;
      hold_lst <= fill_lst;
    end else if (bus.blk_rdy_i) begin
      hold_vld <= 1'b0;
    end
  end
  // sticky error flags; a new error in the clearing cycle wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      ovf_err <= drop || (ovf_err && !bus.err_clr_i);
      frm_err <= frm_fire || (frm_err && !bus.err_clr_i);
    end
  end
  assign bus.blk_d_o = hold_d;
  assign bus.blk_vld_o = hold_vld;
  assign bus.blk_fst_o = hold_fst;
  assign bus.blk_lst_o = hold_lst;
  assign bus.pad_ena_o = ~hold_vld;
  assign bus.ovf_err_o = ovf_err;
  assign bus.frm_err_o = frm_err;
endmodule
